jump_target_packer: RTL
=======================

# jump_target_packer

Multi-cycle packer that turns a 32-bit byte-address jump destination into a J-type instruction word, the encode direction of the jump-target decode path. It shifts the address right by a programmable amount, one bit per cycle. It checks word alignment and, optionally, the 256 MB region, then presents `{opcode, instr_index}` on a valid/ready output. It sits in the loader/relocation path that patches J/JAL words before they are written to instruction memory.

## Interface
- No parameters; all widths fixed (address 32, index 26, opcode 6).
- `clk` in 1: single clock, all state updates on rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `in_valid` in 1: request present.
- `in_ready` out 1: block can accept (high only in IDLE).
- `target_addr` in 32: jump destination byte address.
- `pc_plus4` in 32: address of the delay slot, used for the region check.
- `shift_amt` in 2: right-shift count; 2 for standard MIPS.
- `link` in 1: 0 selects J (opcode 6'b000010), 1 selects JAL (6'b000011).
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts result.
- `instr_word` out 32: `{opcode, index[25:0]}`.
- `err_align` out 1: a nonzero bit was shifted out.
- `err_region` out 1: target[31:28] differs from pc_plus4[31:28].
- `busy` out 1: state is not IDLE.

## Operation
- States: IDLE, SHIFT, CHECK, OUT.
- IDLE: `in_ready`=1. On `in_valid`, capture `target_addr`, `pc_plus4[31:28]`, `link` and `shift_amt` into `cnt`, and clear the sticky bit.
  - Go to SHIFT if `shift_amt`≠0, else CHECK.
- SHIFT: each cycle the working register shifts right by 1, the LSB shifted out ORs into sticky, and `cnt` decrements. Go to CHECK on the cycle `cnt`==1.
- CHECK: register the outputs and go to OUT.
  - `instr_word` = `{opcode, work[25:0]}`.
  - `err_align` = sticky.
  - `err_region` = captured target[31:28] ≠ captured pc[31:28].
- OUT: `out_valid`=1. `instr_word`, `err_*` and `out_valid` hold stable until `out_ready`=1. On that edge, clear `out_valid` and go to IDLE.
- An error does not suppress output; the word is always produced and the error flags accompany it.
- Inputs are sampled only at the accept edge; later changes are ignored.

## Timing
- Accept edge = E0. `out_valid` rises after edge E(`shift_amt`+1), giving latency 1–4 cycles.
- Throughput: at most one request per `shift_amt`+3 cycles with `out_ready` held high (OUT→IDLE takes one edge; no accept in OUT).
- `in_ready` is low from E0 until the edge that consumes the result.
- Reset values: `in_ready`=1, `out_valid`=0, `instr_word`=0, `err_align`=0, `err_region`=0, `busy`=0; state IDLE, `cnt`=0.
- `reset_n` low in any state returns everything to reset values on that edge and discards any in-flight request.
- `in_valid` and `out_ready` high in the same OUT cycle: the result is consumed; the new request is accepted only on the next cycle, in IDLE.

## Configuration
- `JUMP_REGION_CHECK_EN`
  - Defined: `err_region` computed as above and the pc[31:28] capture register exists.
  - Undefined: capture register removed, `err_region` tied to 0, `pc_plus4` unused; all other behaviour identical.

## Test plan
- J, shift 2: target 0x00400024, pc_plus4 0x00400010 → `instr_word`=0x08100009, both errors 0, `out_valid` 3 cycles after accept.
- JAL, same addresses: `instr_word`=0x0C100009. Hold `out_ready` low for 5 cycles: word and `out_valid` stable, `in_ready` stays 0.
- Misaligned: target 0x00400026, shift 2 → `err_align`=1, `instr_word`=0x08100009.
- Region: target 0x10000000, pc_plus4 0x00400010 → `instr_word`=0x08000000. `err_region`=1 with `JUMP_REGION_CHECK_EN`, 0 without.
- Shift 0: target 0x03FFFFFF → `instr_word`=0x0BFFFFFF, `out_valid` 1 cycle after accept, `err_align`=0.
- Reset mid-SHIFT: drop `reset_n` one cycle after accept → next cycle all outputs at reset values, `in_ready`=1. A fresh request then completes correctly.

Source files
------------

// File: rtl/jump_target_packer.sv
// Multi-cycle J/JAL encoder: shifts a byte address into a 26-bit instr_index one bit per cycle.
// Optional `JUMP_REGION_CHECK_EN` enables the 256 MB region check (err_region); otherwise err_region is 0.
module jump_target_packer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] target_addr,
  input  logic [31:0] pc_plus4,
  input  logic [1:0]  shift_amt,
  input  logic        link,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr_word,
  output logic        err_align,
  output logic        err_region,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK, OUT} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_work;
  logic [1:0]  r_cnt;
  logic        r_sticky;
  logic        r_link;
  logic [31:0] r_instr;
  logic        r_err_align;
  logic        r_err_region;
  logic        r_out_valid;
  logic        w_region_mis;
  logic [5:0]  w_opcode;
  logic        w_accept;

  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_opcode = {5'b00001, r_link};

`ifdef JUMP_REGION_CHECK_EN
  // Target's top nibble is captured separately because r_work loses it while shifting.
  logic [3:0] r_pc_hi;
  logic [3:0] r_tgt_hi;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pc_hi  <= 4'd0;
      r_tgt_hi <= 4'd0;
    end else if (w_accept) begin
      r_pc_hi  <= pc_plus4[31:28];
      r_tgt_hi <= target_addr[31:28];
    end
  end

  assign w_region_mis = (r_tgt_hi != r_pc_hi);
`else
  logic w_unused_pc;
  assign w_unused_pc  = ^pc_plus4;
  assign w_region_mis = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_nxt = (shift_amt != 2'd0) ? SHIFT : CHECK;
      SHIFT:   if (r_cnt == 2'd1) w_state_nxt = CHECK;
      CHECK:   w_state_nxt = OUT;
      OUT:     if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_work       <= 32'd0;
      r_cnt        <= 2'd0;
      r_sticky     <= 1'b0;
      r_link       <= 1'b0;
      r_instr      <= 32'd0;
      r_err_align  <= 1'b0;
      r_err_region <= 1'b0;
      r_out_valid  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_work   <= target_addr;
          r_cnt    <= shift_amt;
          r_link   <= link;
          r_sticky <= 1'b0;
        end
        SHIFT: begin
          r_work   <= {1'b0, r_work[31:1]};
          r_sticky <= r_sticky | r_work[0];
          r_cnt    <= r_cnt - 2'd1;
        end
        CHECK: begin
          r_instr      <= {w_opcode, r_work[25:0]};
          r_err_align  <= r_sticky;
          r_err_region <= w_region_mis;
          r_out_valid  <= 1'b1;
        end
        OUT: if (out_ready) r_out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign in_ready   = (r_state == IDLE);
  assign busy       = (r_state != IDLE);
  assign out_valid  = r_out_valid;
  assign instr_word = r_instr;
  assign err_align  = r_err_align;
  assign err_region = r_err_region;

endmodule
